turn_sequencer: RTL and testbench
=================================

Name: turn_sequencer

Overview:
Game-level controller for the two-player snake-and-ladder board. It samples the free-running dice value when the roll button is pressed and applies it to the active player. It enforces the exact-landing rule, then applies the board's ladder/snake jump. It checks for a win and hands the turn to the other player. Its outputs are the player positions, which drive the existing 4-to-16 LED decoders, plus the winner code.

Parameters:
BOARD_MAX, 15, final square index; landing exactly here wins
DICE_MAX, 6, largest legal dice value; any larger input is treated as 0
POS_W, 4, width of a position value

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
roll_btn  in  1  raw roll push-button, asynchronous to clk, active high
dice_in  in  3  current value of the free-running dice counter (0..6)
pos_1  out  POS_W  player 1 position
pos_2  out  POS_W  player 2 position
active_player  out  1  0 = player 1 to move, 1 = player 2 to move
busy  out  1  high while a move is being processed
move_done  out  1  one-cycle pulse when a move completes
last_dice  out  3  dice value applied in the most recent move
winner  out  2  00 none, 01 player 1, 10 player 2

Behaviour:
- Reset (async assert, sync release): pos_1=pos_2=0, active_player=0, busy=0, move_done=0, last_dice=0, winner=00, FSM=IDLE, synchronizer flops=0.
- Input conditioning:
  - roll_btn passes through a 2-flop synchronizer.
  - A rising-edge detect on the synchronized signal gives roll_evt, a 1-cycle pulse.
  - No debounce is done in this block.
- FSM states: IDLE, LATCH, ADVANCE, JUMP, CHECK, OVER.
- IDLE: busy=0. On roll_evt, go to LATCH.
- LATCH:
  - Capture dice into a register d: d = dice_in, or 0 if dice_in > DICE_MAX.
  - last_dice = d. busy=1.
  - Go to ADVANCE.
- ADVANCE:
  - Compute sum = cur + d at POS_W+1 bits, where cur is the active player's position.
  - If sum <= BOARD_MAX, cur = sum. Otherwise cur is unchanged (exact landing required).
  - Go to JUMP.
- JUMP: cur = board_map(cur). Go to CHECK.
- CHECK:
  - move_done=1 for this cycle.
  - If cur == BOARD_MAX: winner = 01 if active_player==0, else 10; go to OVER. active_player is not toggled.
  - Otherwise toggle active_player and go to IDLE.
- OVER:
  - busy=0. roll_evt is ignored and positions are frozen.
  - The FSM stays here until rst_n is asserted.
- Timing and edge cases:
  - Latency: roll_evt in cycle N gives move_done in cycle N+4. FSM is back in IDLE and ready at N+5.
  - roll_evt outside IDLE is dropped, not queued.
  - dice value 0 consumes the turn: position unchanged except for a jump on the current square, then the turn passes.
  - Only the active player's position register may change during a move.
- Reset asserted mid-move aborts the move immediately and restores all reset values.
- A ladder or snake whose destination equals BOARD_MAX counts as a win.

Decomposition:
- Shared package:
  - BOARD_MAX and DICE_MAX.
  - State encoding constants (3-bit).
  - Winner codes: WIN_NONE=00, WIN_P1=01, WIN_P2=10.
  - Jump table constants: ladder 3->9, snake 11->0.
- One sub-module, board_map: combinational, POS_W in / POS_W out. It returns the jump destination, or the input unchanged, and is shared with any future board variants.

Test Plan:
- Reset: assert rst_n=0 mid-ADVANCE -> all outputs return to reset values at once; after release, the first roll moves player 1.
- Ladder: pos_1=0, dice_in=3, pulse roll_btn -> move_done 4 cycles after roll_evt, pos_1=9, pos_2=0, last_dice=3, active_player=1.
- Snake and ignored roll: pos_2=5, dice_in=6 -> pos_2=0. A second roll_btn edge while busy=1 is dropped, so exactly one move_done occurs.
- Overflow hold: pos_1=12, dice_in=5 -> pos_1 stays 12 and active_player toggles. Also dice_in=7 -> last_dice=0 and position unchanged.
- Win: pos_1=9, dice_in=6 -> pos_1=15, winner=01, FSM in OVER, active_player unchanged. Further rolls produce no move_done and no position change.
- Alternation: six rolls with dice 1..6 -> players alternate strictly and each position equals its expected cumulative, mapped value.

Source files
------------

// File: rtl/turn_sequencer_pkg.sv
// turn_sequencer_pkg: shared board constants, FSM state encoding and winner codes.
// Revision 1.0
`default_nettype none

package turn_sequencer_pkg;

  localparam int BOARD_MAX = 15;
  localparam int DICE_MAX  = 6;
  localparam int POS_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_ADVANCE = 3'd2,
    ST_JUMP    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_OVER    = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int LADDER_FROM = 3;
  localparam int LADDER_TO   = 9;
  localparam int SNAKE_FROM  = 11;
  localparam int SNAKE_TO    = 0;

endpackage

`default_nettype wire

// File: rtl/turn_sequencer_board_map.sv
// board_map: combinational ladder/snake lookup; squares without a jump map to themselves.
// Revision 1.0
`default_nettype none

module board_map #(
  parameter int POS_W = 4
) (
  input  logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] dest
);
  import turn_sequencer_pkg::*;

  always_comb begin
    dest = pos;
    if (pos == POS_W'(LADDER_FROM)) begin
      dest = POS_W'(LADDER_TO);
    end else if (pos == POS_W'(SNAKE_FROM)) begin
      dest = POS_W'(SNAKE_TO);
    end
  end

endmodule

`default_nettype wire

// File: rtl/turn_sequencer.sv
// turn_sequencer: two-player snake-and-ladder turn controller (roll, exact landing, jump, win).
// Revision 1.0
`default_nettype none

module turn_sequencer #(
  parameter int BOARD_MAX = turn_sequencer_pkg::BOARD_MAX,
  parameter int DICE_MAX  = turn_sequencer_pkg::DICE_MAX,
  parameter int POS_W     = turn_sequencer_pkg::POS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             roll_btn,
  input  logic [2:0]       dice_in,
  output logic [POS_W-1:0] pos_1,
  output logic [POS_W-1:0] pos_2,
  output logic             active_player,
  output logic             busy,
  output logic             move_done,
  output logic [2:0]       last_dice,
  output logic [1:0]       winner
);
  import turn_sequencer_pkg::*;

  state_t           state;
  logic             sync_1;
  logic             sync_2;
  logic             sync_prev;
  logic             roll_evt;
  logic [POS_W-1:0] cur;
  logic [POS_W-1:0] mapped;
  logic [POS_W:0]   sum;

  assign roll_evt = sync_2 & ~sync_prev;
  assign cur      = active_player ? pos_2 : pos_1;
  // last_dice doubles as the latched dice register for the move in flight
  assign sum      = {1'b0, cur} + (POS_W+1)'(last_dice);

  board_map #(.POS_W(POS_W)) u_board_map (
    .pos  (cur),
    .dest (mapped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      sync_1        <= 1'b0;
      sync_2        <= 1'b0;
      sync_prev     <= 1'b0;
      pos_1         <= '0;
      pos_2         <= '0;
      active_player <= 1'b0;
      busy          <= 1'b0;
      move_done     <= 1'b0;
      last_dice     <= 3'd0;
      winner        <= WIN_NONE;
    end else begin
      sync_1    <= roll_btn;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      move_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (roll_evt) begin
            busy  <= 1'b1;
            state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          last_dice <= (dice_in > 3'(DICE_MAX)) ? 3'd0 : dice_in;
          state     <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (sum <= (POS_W+1)'(BOARD_MAX)) begin
            if (active_player) pos_2 <= sum[POS_W-1:0];
            else               pos_1 <= sum[POS_W-1:0];
          end
          state <= ST_JUMP;
        end
        ST_JUMP: begin
          if (active_player) pos_2 <= mapped;
          else               pos_1 <= mapped;
          move_done <= 1'b1;
          state     <= ST_CHECK;
        end
        ST_CHECK: begin
          busy <= 1'b0;
          if (cur == POS_W'(BOARD_MAX)) begin
            winner <= active_player ? WIN_P2 : WIN_P1;
            state  <= ST_OVER;
          end else begin
            active_player <= ~active_player;
            state         <= ST_IDLE;
          end
        end
        ST_OVER: begin
          state <= ST_OVER;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed and random games against a square-counting game model.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       roll_btn = 1'b0;
  logic [2:0] dice_in = 3'd0;
  logic [3:0] pos_1;
  logic [3:0] pos_2;
  logic       active_player;
  logic       busy;
  logic       move_done;
  logic [2:0] last_dice;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  int m_pos [2];
  int m_active;
  int m_winner;

  always #5 clk = ~clk;

  turn_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .roll_btn      (roll_btn),
    .dice_in       (dice_in),
    .pos_1         (pos_1),
    .pos_2         (pos_2),
    .active_player (active_player),
    .busy          (busy),
    .move_done     (move_done),
    .last_dice     (last_dice),
    .winner        (winner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int board_jump(input int p);
    case (p)
      3:       return 9;
      11:      return 0;
      default: return p;
    endcase
  endfunction

  task automatic model_reset();
    m_pos[0] = 0;
    m_pos[1] = 0;
    m_active = 0;
    m_winner = 0;
  endtask

  task automatic model_move(input int dice);
    int d;
    d = (dice > 6) ? 0 : dice;
    if (m_pos[m_active] + d <= 15) m_pos[m_active] = m_pos[m_active] + d;
    m_pos[m_active] = board_jump(m_pos[m_active]);
    if (m_pos[m_active] == 15) m_winner = m_active + 1;
    else                       m_active = 1 - m_active;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pos_1"}, pos_1, 0);
    check({tag, "_pos_2"}, pos_2, 0);
    check({tag, "_active"}, active_player, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_move_done"}, move_done, 0);
    check({tag, "_last_dice"}, last_dice, 0);
    check({tag, "_winner"}, winner, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    roll_btn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One button press; a double press re-toggles the button while the move is in flight.
  task automatic do_roll(input int dice, input bit double_press);
    int  k;
    int  extra;
    bit  seen;
    bit  live;
    live = (m_winner == 0);
    seen = 1'b0;
    extra = 0;
    @(negedge clk);
    dice_in  = 3'(dice);
    roll_btn = 1'b1;
    for (k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 3 && live) check("busy_in_move", busy, 1);
      if (double_press && k == 2) roll_btn = 1'b0;
      if (double_press && k == 3) roll_btn = 1'b1;
      if (!double_press && k == 4) roll_btn = 1'b0;
      if (move_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (live) begin
      model_move(dice);
      check("move_latency", k, 6);
      check("pos_1", pos_1, m_pos[0]);
      check("pos_2", pos_2, m_pos[1]);
      check("last_dice", last_dice, (dice > 6) ? 0 : dice);
      @(posedge clk);
      #1;
      check("active_after", active_player, m_active);
      check("winner_after", winner, m_winner);
      check("busy_after", busy, 0);
      check("move_done_width", move_done, 0);
    end else begin
      check("over_no_move", seen, 0);
      check("over_pos_1", pos_1, m_pos[0]);
      check("over_pos_2", pos_2, m_pos[1]);
      check("over_winner", winner, m_winner);
      check("over_busy", busy, 0);
    end
    roll_btn = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      if (move_done) extra++;
    end
    check("no_extra_move", extra, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Ladder, invalid dice, snake with a dropped second press, then a win and a frozen board
    do_roll(3, 1'b0);
    do_roll(5, 1'b0);
    do_roll(7, 1'b0);
    do_roll(6, 1'b1);
    do_roll(6, 1'b0);
    do_roll(2, 1'b0);
    do_roll(4, 1'b1);

    // Exact landing: player 1 at 12 rolling 5 stays put
    apply_reset();
    do_roll(6, 1'b0);
    do_roll(0, 1'b0);
    do_roll(6, 1'b0);
    do_roll(0, 1'b0);
    do_roll(5, 1'b0);

    // Strict alternation over dice 1..6
    apply_reset();
    for (int i = 1; i <= 6; i++) do_roll(i, 1'b0);

    // Reset in the middle of a move
    @(negedge clk);
    dice_in  = 3'd2;
    roll_btn = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    roll_btn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_roll(4, 1'b0);
    check("first_after_reset_pos_1", pos_1, 4);

    // Random games
    for (int g = 0; g < 3; g++) begin
      apply_reset();
      for (int r = 0; r < 30 && m_winner == 0; r++) begin
        do_roll(int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
      end
      if (m_winner != 0) do_roll(int'($urandom_range(1, 6)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
